// File: rtl/ysyx_25060173_ifu.sv
// Instruction fetch unit: REQ/WAIT/HOLD/HALT fetch FSM with redirect and kill.
// Optional counters are enabled by defining YSYX_25060173_IFU_PERF_EN.
module ysyx_25060173_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt
`ifdef YSYX_25060173_IFU_PERF_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt
`endif
);

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_HALT
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        kill_q, kill_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic [31:0] tgt;
  logic        req_fire;
  logic        inst_fire;

  assign tgt = {redirect_pc[31:2], 2'b00};

  // Gate with rst_n so no request leaks out while reset is held.
  assign imem_req_valid = rst_n & (state_q == S_REQ);
  assign imem_req_addr  = pc_q;
  assign inst_valid     = (state_q == S_HOLD);
  assign inst           = inst_q;
  assign inst_pc        = inst_pc_q;

  assign req_fire  = imem_req_valid & imem_req_ready;
  assign inst_fire = inst_valid & inst_ready;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    kill_d    = kill_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    unique case (state_q)
      S_REQ: begin
        if (redirect_valid) pc_d = tgt;
        if (req_fire) begin
          state_d = S_WAIT;
          kill_d  = redirect_valid;
        end
      end
      S_WAIT: begin
        if (redirect_valid) begin
          pc_d   = tgt;
          kill_d = 1'b1;
        end
        if (imem_rsp_valid) begin
          // A response racing a redirect belongs to the stale pc.
          if (kill_q | redirect_valid) begin
            kill_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            inst_d    = imem_rsp_data;
            inst_pc_d = pc_q;
            state_d   = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (redirect_valid) begin
          pc_d    = tgt;
          state_d = S_REQ;
        end else if (inst_ready) begin
          pc_d    = pc_q + 32'd4;
          state_d = halt ? S_HALT : S_REQ;
        end
      end
      S_HALT: ;
      default: state_d = S_REQ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_REQ;
      pc_q      <= RESET_PC;
      kill_q    <= 1'b0;
      inst_q    <= 32'h0;
      inst_pc_q <= 32'h0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      kill_q    <= kill_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
    end
  end

`ifdef YSYX_25060173_IFU_PERF_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q <= 32'h0;
      stall_cnt_q <= 32'h0;
    end else begin
      if (inst_fire & ~redirect_valid)
        fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if ((state_q == S_REQ) | (state_q == S_WAIT))
        stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_ysyx_25060173_ifu.sv
// Directed testbench for ysyx_25060173_ifu.
// Perf counter checks run only when YSYX_25060173_IFU_PERF_EN is defined.
module tb_ysyx_25060173_ifu;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
`ifdef YSYX_25060173_IFU_PERF_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  int total;
  int bad;

  ysyx_25060173_ifu #(.RESET_PC(32'h8000_0000)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt)
`ifdef YSYX_25060173_IFU_PERF_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data = 32'h0;
    inst_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    halt = 1'b0;
    step();
    step();
    total++;
    if (imem_req_valid !== 1'b0) begin
      bad++;
      $display("FAIL rst_req_valid got=%b exp=0", imem_req_valid);
    end
    total++;
    if (inst_valid !== 1'b0) begin
      bad++;
      $display("FAIL rst_inst_valid got=%b exp=0", inst_valid);
    end
    total++;
    if (inst !== 32'h0 || inst_pc !== 32'h0) begin
      bad++;
      $display("FAIL rst_inst got=%h/%h exp=0/0", inst, inst_pc);
    end
    rst_n = 1'b1;
    #1;
    total++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0000) begin
      bad++;
      $display("FAIL rst_first_req got=%b/%h exp=1/80000000",
               imem_req_valid, imem_req_addr);
    end
  endtask

  task automatic test_ready_stall;
    imem_req_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      total++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0000) begin
        bad++;
        $display("FAIL stall_hold cyc=%0d got=%b/%h exp=1/80000000",
                 i, imem_req_valid, imem_req_addr);
      end
    end
    // A stray response while in REQ must be ignored.
    imem_rsp_valid = 1'b1;
    imem_rsp_data = 32'hDEAD_BEEF;
    step();
    imem_rsp_valid = 1'b0;
    total++;
    if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1) begin
      bad++;
      $display("FAIL stray_rsp got=%b/%b exp=0/1", inst_valid, imem_req_valid);
    end
  endtask

  task automatic test_fetch;
    imem_req_ready = 1'b1;
    inst_ready = 1'b1;
    step();
    total++;
    if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin
      bad++;
      $display("FAIL fetch_wait got=%b/%b exp=0/0", imem_req_valid, inst_valid);
    end
    imem_rsp_valid = 1'b1;
    imem_rsp_data = 32'h0000_0413;
    step();
    imem_rsp_valid = 1'b0;
    total++;
    if (inst_valid !== 1'b1 || inst !== 32'h0000_0413 || inst_pc !== 32'h8000_0000) begin
      bad++;
      $display("FAIL fetch_hold got=%b/%h/%h exp=1/00000413/80000000",
               inst_valid, inst, inst_pc);
    end
    step();
    inst_ready = 1'b0;
    total++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0004) begin
      bad++;
      $display("FAIL fetch_next got=%b/%h exp=1/80000004",
               imem_req_valid, imem_req_addr);
    end
  endtask

  task automatic test_redirect_wait;
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h8000_0102;
    step();
    redirect_valid = 1'b0;
    step();
    step();
    total++;
    if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin
      bad++;
      $display("FAIL rdw_wait got=%b/%b exp=0/0", imem_req_valid, inst_valid);
    end
    imem_rsp_valid = 1'b1;
    imem_rsp_data = 32'h0010_0073;
    step();
    imem_rsp_valid = 1'b0;
    total++;
    if (inst_valid !== 1'b0) begin
      bad++;
      $display("FAIL rdw_discard got=%b exp=0", inst_valid);
    end
    total++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0100) begin
      bad++;
      $display("FAIL rdw_addr got=%b/%h exp=1/80000100",
               imem_req_valid, imem_req_addr);
    end
  endtask

  task automatic test_hold;
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data = 32'h00A0_0093;
    step();
    imem_rsp_valid = 1'b0;
    inst_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (inst_valid !== 1'b1 || inst !== 32'h00A0_0093 || inst_pc !== 32'h8000_0100) begin
        bad++;
        $display("FAIL hold_stable cyc=%0d got=%b/%h/%h exp=1/00a00093/80000100",
                 i, inst_valid, inst, inst_pc);
      end
      step();
    end
    redirect_valid = 1'b1;
    redirect_pc = 32'h8000_0200;
    inst_ready = 1'b1;
    step();
    redirect_valid = 1'b0;
    inst_ready = 1'b0;
    total++;
    if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0200) begin
      bad++;
      $display("FAIL hold_redirect got=%b/%b/%h exp=0/1/80000200",
               inst_valid, imem_req_valid, imem_req_addr);
    end
  endtask

  task automatic test_redirect_req;
    imem_req_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h8000_0300;
    step();
    imem_req_ready = 1'b0;
    redirect_valid = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data = 32'h1111_1111;
    step();
    imem_rsp_valid = 1'b0;
    total++;
    if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0300) begin
      bad++;
      $display("FAIL req_kill got=%b/%b/%h exp=0/1/80000300",
               inst_valid, imem_req_valid, imem_req_addr);
    end
  endtask

  task automatic test_wrap;
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFF;
    step();
    redirect_valid = 1'b0;
    total++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'hFFFF_FFFC) begin
      bad++;
      $display("FAIL wrap_align got=%b/%h exp=1/fffffffc",
               imem_req_valid, imem_req_addr);
    end
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data = 32'h2222_2222;
    step();
    imem_rsp_valid = 1'b0;
    total++;
    if (inst_pc !== 32'hFFFF_FFFC || inst !== 32'h2222_2222) begin
      bad++;
      $display("FAIL wrap_inst got=%h/%h exp=fffffffc/22222222", inst_pc, inst);
    end
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
    total++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
      bad++;
      $display("FAIL wrap_next got=%b/%h exp=1/00000000",
               imem_req_valid, imem_req_addr);
    end
  endtask

`ifdef YSYX_25060173_IFU_PERF_EN
  task automatic test_perf;
    rst_n = 1'b0;
    step();
    total++;
    if (perf_fetch_cnt !== 32'd0 || perf_stall_cnt !== 32'd0) begin
      bad++;
      $display("FAIL perf_reset got=%0d/%0d exp=0/0", perf_fetch_cnt, perf_stall_cnt);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      imem_req_ready = 1'b1;
      inst_ready = 1'b1;
      step();
      imem_rsp_valid = 1'b1;
      imem_rsp_data = 32'h0000_0013;
      step();
      imem_rsp_valid = 1'b0;
      step();
    end
    imem_req_ready = 1'b0;
    inst_ready = 1'b0;
    total++;
    if (perf_fetch_cnt !== 32'd10 || perf_stall_cnt !== 32'd20) begin
      bad++;
      $display("FAIL perf_counts got=%0d/%0d exp=10/20", perf_fetch_cnt, perf_stall_cnt);
    end
  endtask
`endif

  task automatic test_halt;
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data = 32'h0010_0073;
    step();
    imem_rsp_valid = 1'b0;
    halt = 1'b1;
    inst_ready = 1'b1;
    step();
    halt = 1'b0;
    inst_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      total++;
      if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin
        bad++;
        $display("FAIL halt_quiet cyc=%0d got=%b/%b exp=0/0",
                 i, imem_req_valid, inst_valid);
      end
      redirect_valid = (i == 5);
      redirect_pc = 32'h8000_0400;
      imem_req_ready = (i >= 5);
      step();
    end
    redirect_valid = 1'b0;
    imem_req_ready = 1'b0;
    total++;
    if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin
      bad++;
      $display("FAIL halt_redirect got=%b/%b exp=0/0", imem_req_valid, inst_valid);
    end
  endtask

  task automatic test_reset_wait;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    total++;
    if (imem_req_valid !== 1'b0) begin
      bad++;
      $display("FAIL rw_in_wait got=%b exp=0", imem_req_valid);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin
      bad++;
      $display("FAIL rw_reset got=%b/%b exp=0/0", imem_req_valid, inst_valid);
    end
    step();
    rst_n = 1'b1;
    imem_rsp_valid = 1'b1;
    imem_rsp_data = 32'h3333_3333;
    step();
    imem_rsp_valid = 1'b0;
    total++;
    if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0000) begin
      bad++;
      $display("FAIL rw_late_rsp got=%b/%b/%h exp=0/1/80000000",
               inst_valid, imem_req_valid, imem_req_addr);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_ready_stall();
    test_fetch();
    test_redirect_wait();
    test_hold();
    test_redirect_req();
    test_wrap();
`ifdef YSYX_25060173_IFU_PERF_EN
    test_perf();
`endif
    test_halt();
    test_reset_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
